// File: rtl/axi_mem_pkg.sv
// Shared types and AXI encodings for the simple-mem to AXI4 master bridge.
package axi_mem_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReadAddr,
    StReadData,
    StWriteAddr,
    StWriteData,
    StWriteAck
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic       MEM_OP_RD      = 1'b0;
  localparam logic       MEM_OP_WR      = 1'b1;

endpackage

// File: rtl/axi_mem_master_if.sv
// AXI4 bus bundle for the m_axi_gmem port; master drives AR/AW/W and the R/B ready lines.
interface axi_mem_master_if #(
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned DATA_BITS = 64,
  parameter int unsigned ID_BITS   = 1,
  parameter int unsigned USER_BITS = 1
);
  localparam int unsigned STRB_BITS = DATA_BITS / 8;

  logic                 arvalid, arready;
  logic [ADDR_BITS-1:0] araddr;
  logic [ID_BITS-1:0]   arid;
  logic [7:0]           arlen;
  logic [2:0]           arsize;
  logic [1:0]           arburst;
  logic                 arlock;
  logic [3:0]           arcache, arqos, arregion;
  logic [2:0]           arprot;
  logic [USER_BITS-1:0] aruser;

  logic                 rvalid, rready, rlast;
  logic [DATA_BITS-1:0] rdata;
  logic [ID_BITS-1:0]   rid;
  logic [USER_BITS-1:0] ruser;
  logic [1:0]           rresp;

  logic                 awvalid, awready;
  logic [ADDR_BITS-1:0] awaddr;
  logic [ID_BITS-1:0]   awid;
  logic [7:0]           awlen;
  logic [2:0]           awsize;
  logic [1:0]           awburst;
  logic                 awlock;
  logic [3:0]           awcache, awqos, awregion;
  logic [2:0]           awprot;
  logic [USER_BITS-1:0] awuser;

  logic                 wvalid, wready, wlast;
  logic [DATA_BITS-1:0] wdata;
  logic [STRB_BITS-1:0] wstrb;
  logic [ID_BITS-1:0]   wid;
  logic [USER_BITS-1:0] wuser;

  logic                 bvalid, bready;
  logic [1:0]           bresp;
  logic [ID_BITS-1:0]   bid;
  logic [USER_BITS-1:0] buser;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos,
           arregion, aruser, rready,
           awvalid, awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos,
           awregion, awuser,
           wvalid, wdata, wstrb, wlast, wid, wuser, bready,
    input  arready, rvalid, rdata, rlast, rid, ruser, rresp,
           awready, wready, bvalid, bresp, bid, buser
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos,
           arregion, aruser, rready,
           awvalid, awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos,
           awregion, awuser,
           wvalid, wdata, wstrb, wlast, wid, wuser, bready,
    output arready, rvalid, rdata, rlast, rid, ruser, rresp,
           awready, wready, bvalid, bresp, bid, buser
  );

endinterface

// File: rtl/axi_mem_master.sv
// Bridges simple mem request/read/write streams onto AXI4 bursts, one transaction at a time.
// R and W data pass straight through; only addresses, length and beat count are registered.
module axi_mem_master
  import axi_mem_pkg::*;
#(
  parameter int unsigned MEM_LEN_BITS      = 8,
  parameter int unsigned MEM_ADDR_BITS     = 32,
  parameter int unsigned MEM_DATA_BITS     = 64,
  parameter int unsigned MEM_AXI_DATA_BITS = 64,
  parameter int unsigned MEM_AXI_ADDR_BITS = 32,
  parameter int unsigned MEM_AXI_ID_BITS   = 1,
  parameter int unsigned MEM_AXI_USER_BITS = 1,
  parameter int unsigned MEM_AXI_STRB_BITS = MEM_AXI_DATA_BITS / 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     mem_req_valid,
  output logic                     mem_req_ready,
  input  logic                     mem_req_opcode,
  input  logic [MEM_LEN_BITS-1:0]  mem_req_len,
  input  logic [MEM_ADDR_BITS-1:0] mem_req_addr,
  input  logic                     mem_wr_valid,
  output logic                     mem_wr_ready,
  input  logic [MEM_DATA_BITS-1:0] mem_wr_bits,
  output logic                     mem_rd_valid,
  input  logic                     mem_rd_ready,
  output logic [MEM_DATA_BITS-1:0] mem_rd_bits,
  output logic                     err,
  axi_mem_master_if.master         m_axi_gmem
);

  localparam logic [2:0] AXI_SIZE = 3'($clog2(MEM_AXI_STRB_BITS));

  state_t                   state_q;
  logic [MEM_ADDR_BITS-1:0] addr_q;
  logic [MEM_LEN_BITS-1:0]  len_q;
  logic [MEM_LEN_BITS-1:0]  cnt_q;
  logic                     err_q;

  logic in_rd, in_wr, r_hs, w_hs, b_hs, w_last;

  assign in_rd  = (state_q == StReadData);
  assign in_wr  = (state_q == StWriteData);
  assign w_last = (cnt_q == '0);
  assign r_hs   = in_rd && m_axi_gmem.rvalid && mem_rd_ready;
  assign w_hs   = in_wr && mem_wr_valid && m_axi_gmem.wready;
  assign b_hs   = (state_q == StWriteAck) && m_axi_gmem.bvalid;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mem_req_valid) begin
            addr_q  <= mem_req_addr;
            len_q   <= mem_req_len;
            cnt_q   <= mem_req_len;
            state_q <= (mem_req_opcode == MEM_OP_RD) ? StReadAddr : StWriteAddr;
          end
        end
        StReadAddr:  if (m_axi_gmem.arready) state_q <= StReadData;
        StReadData:  if (r_hs && m_axi_gmem.rlast) state_q <= StIdle;
        StWriteAddr: if (m_axi_gmem.awready) state_q <= StWriteData;
        StWriteData: begin
          if (w_hs) begin
            if (w_last) state_q <= StWriteAck;
            else        cnt_q   <= cnt_q - 1'b1;
          end
        end
        StWriteAck:  if (m_axi_gmem.bvalid) state_q <= StIdle;
        default:     state_q <= StIdle;
      endcase
      // Sticky: only reset clears a reported slave error.
      if ((r_hs && m_axi_gmem.rresp != AXI_RESP_OKAY) ||
          (b_hs && m_axi_gmem.bresp != AXI_RESP_OKAY)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign mem_req_ready = (state_q == StIdle);
  assign mem_rd_valid  = in_rd && m_axi_gmem.rvalid;
  assign mem_rd_bits   = m_axi_gmem.rdata;
  assign mem_wr_ready  = in_wr && m_axi_gmem.wready;
  assign err           = err_q;

  assign m_axi_gmem.arvalid  = (state_q == StReadAddr);
  assign m_axi_gmem.araddr   = MEM_AXI_ADDR_BITS'(addr_q);
  assign m_axi_gmem.arid     = {MEM_AXI_ID_BITS{1'b0}};
  assign m_axi_gmem.arlen    = 8'(len_q);
  assign m_axi_gmem.arsize   = AXI_SIZE;
  assign m_axi_gmem.arburst  = AXI_BURST_INCR;
  assign m_axi_gmem.arlock   = 1'b0;
  assign m_axi_gmem.arcache  = 4'd0;
  assign m_axi_gmem.arprot   = 3'd0;
  assign m_axi_gmem.arqos    = 4'd0;
  assign m_axi_gmem.arregion = 4'd0;
  assign m_axi_gmem.aruser   = {MEM_AXI_USER_BITS{1'b0}};
  assign m_axi_gmem.rready   = in_rd && mem_rd_ready;

  assign m_axi_gmem.awvalid  = (state_q == StWriteAddr);
  assign m_axi_gmem.awaddr   = MEM_AXI_ADDR_BITS'(addr_q);
  assign m_axi_gmem.awid     = {MEM_AXI_ID_BITS{1'b0}};
  assign m_axi_gmem.awlen    = 8'(len_q);
  assign m_axi_gmem.awsize   = AXI_SIZE;
  assign m_axi_gmem.awburst  = AXI_BURST_INCR;
  assign m_axi_gmem.awlock   = 1'b0;
  assign m_axi_gmem.awcache  = 4'd0;
  assign m_axi_gmem.awprot   = 3'd0;
  assign m_axi_gmem.awqos    = 4'd0;
  assign m_axi_gmem.awregion = 4'd0;
  assign m_axi_gmem.awuser   = {MEM_AXI_USER_BITS{1'b0}};

  assign m_axi_gmem.wvalid   = in_wr && mem_wr_valid;
  assign m_axi_gmem.wdata    = mem_wr_bits;
  assign m_axi_gmem.wstrb    = {MEM_AXI_STRB_BITS{1'b1}};
  assign m_axi_gmem.wlast    = w_last;
  assign m_axi_gmem.wid      = {MEM_AXI_ID_BITS{1'b0}};
  assign m_axi_gmem.wuser    = {MEM_AXI_USER_BITS{1'b0}};
  assign m_axi_gmem.bready   = (state_q == StWriteAck);

  // Response IDs/user bits carry no information with a single outstanding transaction.
  logic unused_resp;
  assign unused_resp = ^{m_axi_gmem.rid, m_axi_gmem.ruser, m_axi_gmem.bid, m_axi_gmem.buser};

endmodule

// File: tb/tb_axi_mem_master.sv
// Directed bench for axi_mem_master: the bench plays the AXI slave and the mem-side client.
module tb_axi_mem_master;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_req_valid, mem_req_ready, mem_req_opcode;
  logic [7:0]  mem_req_len;
  logic [31:0] mem_req_addr;
  logic        mem_wr_valid, mem_wr_ready;
  logic [63:0] mem_wr_bits;
  logic        mem_rd_valid, mem_rd_ready;
  logic [63:0] mem_rd_bits;
  logic        err;

  int vectors = 0;
  int miscompares = 0;

  axi_mem_master_if #(.ADDR_BITS(32), .DATA_BITS(64), .ID_BITS(1), .USER_BITS(1)) m_axi_gmem ();

  axi_mem_master dut (
    .clock          (clock),
    .reset          (reset),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_opcode (mem_req_opcode),
    .mem_req_len    (mem_req_len),
    .mem_req_addr   (mem_req_addr),
    .mem_wr_valid   (mem_wr_valid),
    .mem_wr_ready   (mem_wr_ready),
    .mem_wr_bits    (mem_wr_bits),
    .mem_rd_valid   (mem_rd_valid),
    .mem_rd_ready   (mem_rd_ready),
    .mem_rd_bits    (mem_rd_bits),
    .err            (err),
    .m_axi_gmem     (m_axi_gmem)
  );

  always #5 clock = ~clock;

  // Inputs change on the falling edge; checks follow 1 ns later, well clear of the rising edge.
  task automatic test_reset();
    reset = 1'b1;
    mem_rd_ready = 1'b1;
    mem_wr_valid = 1'b1;
    m_axi_gmem.rvalid = 1'b1;
    m_axi_gmem.wready = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    vectors++; if (mem_req_ready !== 1'b1) begin miscompares++;
      $display("FAIL rst_req_ready: got %b want 1", mem_req_ready); end
    vectors++; if (mem_rd_valid !== 1'b0 || mem_wr_ready !== 1'b0) begin miscompares++;
      $display("FAIL rst_mem_hs: got rd_valid=%b wr_ready=%b want 0 0", mem_rd_valid,
               mem_wr_ready); end
    vectors++; if ({m_axi_gmem.arvalid, m_axi_gmem.awvalid, m_axi_gmem.wvalid,
                    m_axi_gmem.rready, m_axi_gmem.bready} !== 5'b0) begin miscompares++;
      $display("FAIL rst_axi_hs: got ar=%b aw=%b w=%b r=%b b=%b want all 0",
               m_axi_gmem.arvalid, m_axi_gmem.awvalid, m_axi_gmem.wvalid,
               m_axi_gmem.rready, m_axi_gmem.bready); end
    vectors++; if (err !== 1'b0) begin miscompares++;
      $display("FAIL rst_err: got %b want 0", err); end
    mem_rd_ready = 1'b0;
    mem_wr_valid = 1'b0;
    m_axi_gmem.rvalid = 1'b0;
    m_axi_gmem.wready = 1'b0;
  endtask

  task automatic test_read_burst();
    @(negedge clock);
    mem_req_valid = 1'b1; mem_req_opcode = 1'b0; mem_req_len = 8'd3; mem_req_addr = 32'h1000;
    #1;
    vectors++; if (mem_req_ready !== 1'b1) begin miscompares++;
      $display("FAIL rd_req_ready: got %b want 1", mem_req_ready); end
    @(negedge clock);
    mem_req_valid = 1'b0; mem_req_addr = 32'hdead_beef; mem_req_len = 8'd9;
    // Two cycles with ARREADY low, then the handshake cycle: AR must hold steady throughout.
    for (int c = 0; c < 3; c++) begin
      m_axi_gmem.arready = (c == 2);
      #1;
      vectors++; if (m_axi_gmem.arvalid !== 1'b1 || m_axi_gmem.araddr !== 32'h1000 ||
                     m_axi_gmem.arlen !== 8'd3 || m_axi_gmem.arsize !== 3'd3 ||
                     m_axi_gmem.arburst !== 2'b01) begin miscompares++;
        $display("FAIL rd_ar_hold[%0d]: got v=%b a=%h len=%0d size=%0d burst=%0d want 1 1000 3 3 1",
                 c, m_axi_gmem.arvalid, m_axi_gmem.araddr, m_axi_gmem.arlen,
                 m_axi_gmem.arsize, m_axi_gmem.arburst); end
      @(negedge clock);
    end
    m_axi_gmem.arready = 1'b0;
    mem_rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_axi_gmem.rvalid = 1'b1;
      m_axi_gmem.rdata  = 64'hA5A5_0000_0000_0010 + 64'(i);
      m_axi_gmem.rlast  = (i == 3);
      m_axi_gmem.rresp  = 2'b00;
      #1;
      vectors++; if (mem_rd_valid !== 1'b1 || m_axi_gmem.rready !== 1'b1 ||
                     mem_rd_bits !== 64'hA5A5_0000_0000_0010 + 64'(i)) begin miscompares++;
        $display("FAIL rd_beat[%0d]: got v=%b rr=%b d=%h want 1 1 %h", i, mem_rd_valid,
                 m_axi_gmem.rready, mem_rd_bits, 64'hA5A5_0000_0000_0010 + 64'(i)); end
      @(negedge clock);
    end
    m_axi_gmem.rvalid = 1'b0; m_axi_gmem.rlast = 1'b0;
    #1;
    vectors++; if (mem_req_ready !== 1'b1 || m_axi_gmem.rready !== 1'b0) begin miscompares++;
      $display("FAIL rd_done_idle: got req_ready=%b rready=%b want 1 0", mem_req_ready,
               m_axi_gmem.rready); end
    mem_rd_ready = 1'b0;
  endtask

  task automatic test_write();
    @(negedge clock);
    mem_req_valid = 1'b1; mem_req_opcode = 1'b1; mem_req_len = 8'd1; mem_req_addr = 32'h2000;
    @(negedge clock);
    mem_req_valid = 1'b0;
    m_axi_gmem.awready = 1'b1;
    #1;
    vectors++; if (m_axi_gmem.awvalid !== 1'b1 || m_axi_gmem.awlen !== 8'd1 ||
                   m_axi_gmem.awaddr !== 32'h2000) begin miscompares++;
      $display("FAIL wr_aw: got v=%b len=%0d a=%h want 1 1 2000", m_axi_gmem.awvalid,
               m_axi_gmem.awlen, m_axi_gmem.awaddr); end
    @(negedge clock);
    m_axi_gmem.awready = 1'b0;
    m_axi_gmem.wready = 1'b1;
    mem_wr_valid = 1'b1; mem_wr_bits = 64'hAAAA_AAAA_0000_0001;
    #1;
    vectors++; if (m_axi_gmem.wvalid !== 1'b1 || m_axi_gmem.wlast !== 1'b0 ||
                   m_axi_gmem.wdata !== 64'hAAAA_AAAA_0000_0001 || m_axi_gmem.wstrb !== 8'hFF ||
                   mem_wr_ready !== 1'b1) begin miscompares++;
      $display("FAIL wr_beat_a: got v=%b last=%b d=%h strb=%h rdy=%b want 1 0 aaaaaaaa00000001 ff 1",
               m_axi_gmem.wvalid, m_axi_gmem.wlast, m_axi_gmem.wdata, m_axi_gmem.wstrb,
               mem_wr_ready); end
    @(negedge clock);
    mem_wr_bits = 64'hBBBB_BBBB_0000_0002;
    #1;
    vectors++; if (m_axi_gmem.wlast !== 1'b1 || m_axi_gmem.wdata !== 64'hBBBB_BBBB_0000_0002)
      begin miscompares++;
      $display("FAIL wr_beat_b: got last=%b d=%h want 1 bbbbbbbb00000002", m_axi_gmem.wlast,
               m_axi_gmem.wdata); end
    @(negedge clock);
    mem_wr_valid = 1'b0; m_axi_gmem.wready = 1'b0;
    m_axi_gmem.bvalid = 1'b1; m_axi_gmem.bresp = 2'b00;
    #1;
    vectors++; if (m_axi_gmem.bready !== 1'b1 || mem_req_ready !== 1'b0) begin miscompares++;
      $display("FAIL wr_ack: got bready=%b req_ready=%b want 1 0", m_axi_gmem.bready,
               mem_req_ready); end
    @(negedge clock);
    m_axi_gmem.bvalid = 1'b0;
    #1;
    vectors++; if (mem_req_ready !== 1'b1 || m_axi_gmem.bready !== 1'b0) begin miscompares++;
      $display("FAIL wr_done_idle: got req_ready=%b bready=%b want 1 0", mem_req_ready,
               m_axi_gmem.bready); end
  endtask

  task automatic test_rd_backpressure();
    @(negedge clock);
    mem_req_valid = 1'b1; mem_req_opcode = 1'b0; mem_req_len = 8'd3; mem_req_addr = 32'h3000;
    @(negedge clock);
    mem_req_valid = 1'b0; m_axi_gmem.arready = 1'b1;
    @(negedge clock);
    m_axi_gmem.arready = 1'b0;
    m_axi_gmem.rvalid = 1'b1; m_axi_gmem.rresp = 2'b00;
    for (int i = 0; i < 4; i++) begin
      m_axi_gmem.rdata = 64'hC0DE_0000_0000_0000 + 64'(i);
      m_axi_gmem.rlast = (i == 3);
      if (i == 1) begin
        mem_rd_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          #1;
          vectors++; if (m_axi_gmem.rready !== 1'b0 || mem_rd_valid !== 1'b1 ||
                         mem_req_ready !== 1'b0) begin miscompares++;
            $display("FAIL rd_stall[%0d]: got rready=%b rd_valid=%b req_ready=%b want 0 1 0",
                     s, m_axi_gmem.rready, mem_rd_valid, mem_req_ready); end
          @(negedge clock);
        end
      end
      mem_rd_ready = 1'b1;
      #1;
      vectors++; if (m_axi_gmem.rready !== 1'b1 ||
                     mem_rd_bits !== 64'hC0DE_0000_0000_0000 + 64'(i)) begin miscompares++;
        $display("FAIL rd_bp_beat[%0d]: got rready=%b d=%h want 1 %h", i, m_axi_gmem.rready,
                 mem_rd_bits, 64'hC0DE_0000_0000_0000 + 64'(i)); end
      @(negedge clock);
    end
    m_axi_gmem.rvalid = 1'b0; m_axi_gmem.rlast = 1'b0; mem_rd_ready = 1'b0;
    #1;
    vectors++; if (mem_req_ready !== 1'b1) begin miscompares++;
      $display("FAIL rd_bp_idle: got req_ready=%b want 1", mem_req_ready); end
  endtask

  task automatic test_wr_gaps();
    @(negedge clock);
    mem_req_valid = 1'b1; mem_req_opcode = 1'b1; mem_req_len = 8'd2; mem_req_addr = 32'h4000;
    @(negedge clock);
    mem_req_valid = 1'b0; m_axi_gmem.awready = 1'b1;
    @(negedge clock);
    m_axi_gmem.awready = 1'b0; m_axi_gmem.wready = 1'b1;
    mem_wr_valid = 1'b1; mem_wr_bits = 64'h1111;
    @(negedge clock);
    mem_wr_valid = 1'b0;
    for (int g = 0; g < 2; g++) begin
      #1;
      vectors++; if (m_axi_gmem.wvalid !== 1'b0 || m_axi_gmem.wlast !== 1'b0) begin miscompares++;
        $display("FAIL wr_gap[%0d]: got wvalid=%b wlast=%b want 0 0", g, m_axi_gmem.wvalid,
                 m_axi_gmem.wlast); end
      @(negedge clock);
    end
    mem_wr_valid = 1'b1; mem_wr_bits = 64'h2222;
    #1;
    vectors++; if (m_axi_gmem.wvalid !== 1'b1 || m_axi_gmem.wlast !== 1'b0) begin miscompares++;
      $display("FAIL wr_gap_mid: got wvalid=%b wlast=%b want 1 0", m_axi_gmem.wvalid,
               m_axi_gmem.wlast); end
    @(negedge clock);
    mem_wr_bits = 64'h3333;
    #1;
    vectors++; if (m_axi_gmem.wvalid !== 1'b1 || m_axi_gmem.wlast !== 1'b1) begin miscompares++;
      $display("FAIL wr_gap_last: got wvalid=%b wlast=%b want 1 1", m_axi_gmem.wvalid,
               m_axi_gmem.wlast); end
    @(negedge clock);
    mem_wr_valid = 1'b0; m_axi_gmem.wready = 1'b0;
    m_axi_gmem.bvalid = 1'b1; m_axi_gmem.bresp = 2'b00;
    @(negedge clock);
    m_axi_gmem.bvalid = 1'b0;
  endtask

  task automatic test_busy_req();
    @(negedge clock);
    mem_req_valid = 1'b1; mem_req_opcode = 1'b1; mem_req_len = 8'd0; mem_req_addr = 32'h5000;
    @(negedge clock);
    // Queue a read behind the write; it must wait until the write completes.
    mem_req_opcode = 1'b0; mem_req_addr = 32'h6000;
    m_axi_gmem.awready = 1'b1;
    #1;
    vectors++; if (mem_req_ready !== 1'b0 || m_axi_gmem.arvalid !== 1'b0) begin miscompares++;
      $display("FAIL busy_aw: got req_ready=%b arvalid=%b want 0 0", mem_req_ready,
               m_axi_gmem.arvalid); end
    @(negedge clock);
    m_axi_gmem.awready = 1'b0; m_axi_gmem.wready = 1'b1;
    mem_wr_valid = 1'b1; mem_wr_bits = 64'h5555;
    #1;
    vectors++; if (m_axi_gmem.wlast !== 1'b1 || mem_req_ready !== 1'b0 ||
                   m_axi_gmem.arvalid !== 1'b0) begin miscompares++;
      $display("FAIL busy_w_single: got wlast=%b req_ready=%b arvalid=%b want 1 0 0",
               m_axi_gmem.wlast, mem_req_ready, m_axi_gmem.arvalid); end
    @(negedge clock);
    mem_wr_valid = 1'b0; m_axi_gmem.wready = 1'b0;
    m_axi_gmem.bvalid = 1'b1; m_axi_gmem.bresp = 2'b00;
    #1;
    vectors++; if (mem_req_ready !== 1'b0) begin miscompares++;
      $display("FAIL busy_b: got req_ready=%b want 0", mem_req_ready); end
    @(negedge clock);
    m_axi_gmem.bvalid = 1'b0;
    #1;
    vectors++; if (mem_req_ready !== 1'b1 || m_axi_gmem.arvalid !== 1'b0) begin miscompares++;
      $display("FAIL busy_idle: got req_ready=%b arvalid=%b want 1 0", mem_req_ready,
               m_axi_gmem.arvalid); end
    @(negedge clock);
    mem_req_valid = 1'b0; m_axi_gmem.arready = 1'b1;
    #1;
    vectors++; if (m_axi_gmem.arvalid !== 1'b1 || m_axi_gmem.arlen !== 8'd0 ||
                   m_axi_gmem.araddr !== 32'h6000) begin miscompares++;
      $display("FAIL busy_ar: got v=%b len=%0d a=%h want 1 0 6000", m_axi_gmem.arvalid,
               m_axi_gmem.arlen, m_axi_gmem.araddr); end
    @(negedge clock);
    m_axi_gmem.arready = 1'b0; mem_rd_ready = 1'b1;
    m_axi_gmem.rvalid = 1'b1; m_axi_gmem.rlast = 1'b1; m_axi_gmem.rdata = 64'h6666;
    @(negedge clock);
    m_axi_gmem.rvalid = 1'b0; m_axi_gmem.rlast = 1'b0; mem_rd_ready = 1'b0;
  endtask

  task automatic test_bresp_err();
    @(negedge clock);
    mem_req_valid = 1'b1; mem_req_opcode = 1'b1; mem_req_len = 8'd0; mem_req_addr = 32'h7000;
    @(negedge clock);
    mem_req_valid = 1'b0; m_axi_gmem.awready = 1'b1;
    @(negedge clock);
    m_axi_gmem.awready = 1'b0; m_axi_gmem.wready = 1'b1; mem_wr_valid = 1'b1;
    @(negedge clock);
    mem_wr_valid = 1'b0; m_axi_gmem.wready = 1'b0;
    m_axi_gmem.bvalid = 1'b1; m_axi_gmem.bresp = 2'b10;
    #1;
    vectors++; if (err !== 1'b0) begin miscompares++;
      $display("FAIL err_before_b: got %b want 0", err); end
    @(negedge clock);
    m_axi_gmem.bvalid = 1'b0; m_axi_gmem.bresp = 2'b00;
    #1;
    vectors++; if (err !== 1'b1) begin miscompares++;
      $display("FAIL err_set: got %b want 1", err); end
    // A clean read afterwards must not clear the flag.
    @(negedge clock);
    mem_req_valid = 1'b1; mem_req_opcode = 1'b0; mem_req_len = 8'd0; mem_req_addr = 32'h7100;
    @(negedge clock);
    mem_req_valid = 1'b0; m_axi_gmem.arready = 1'b1;
    @(negedge clock);
    m_axi_gmem.arready = 1'b0; mem_rd_ready = 1'b1;
    m_axi_gmem.rvalid = 1'b1; m_axi_gmem.rlast = 1'b1; m_axi_gmem.rresp = 2'b00;
    @(negedge clock);
    m_axi_gmem.rvalid = 1'b0; m_axi_gmem.rlast = 1'b0; mem_rd_ready = 1'b0;
    #1;
    vectors++; if (err !== 1'b1 || mem_req_ready !== 1'b1) begin miscompares++;
      $display("FAIL err_sticky: got err=%b req_ready=%b want 1 1", err, mem_req_ready); end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    mem_req_valid = 1'b1; mem_req_opcode = 1'b0; mem_req_len = 8'd3; mem_req_addr = 32'h8000;
    @(negedge clock);
    mem_req_valid = 1'b0; m_axi_gmem.arready = 1'b1;
    @(negedge clock);
    m_axi_gmem.arready = 1'b0; mem_rd_ready = 1'b1;
    m_axi_gmem.rvalid = 1'b1; m_axi_gmem.rlast = 1'b0; m_axi_gmem.rresp = 2'b00;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    vectors++; if (mem_req_ready !== 1'b1 || m_axi_gmem.rready !== 1'b0 ||
                   m_axi_gmem.arvalid !== 1'b0 || mem_rd_valid !== 1'b0 || err !== 1'b0)
      begin miscompares++;
      $display("FAIL rst_mid: got req_ready=%b rready=%b arvalid=%b rd_valid=%b err=%b want 1 0 0 0 0",
               mem_req_ready, m_axi_gmem.rready, m_axi_gmem.arvalid, mem_rd_valid, err); end
    m_axi_gmem.rvalid = 1'b0; mem_rd_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    mem_req_valid = 1'b0; mem_req_opcode = 1'b0; mem_req_len = '0; mem_req_addr = '0;
    mem_wr_valid = 1'b0; mem_wr_bits = '0; mem_rd_ready = 1'b0;
    m_axi_gmem.arready = 1'b0; m_axi_gmem.awready = 1'b0; m_axi_gmem.wready = 1'b0;
    m_axi_gmem.rvalid = 1'b0; m_axi_gmem.rdata = '0; m_axi_gmem.rlast = 1'b0;
    m_axi_gmem.rid = '0; m_axi_gmem.ruser = '0; m_axi_gmem.rresp = 2'b00;
    m_axi_gmem.bvalid = 1'b0; m_axi_gmem.bresp = 2'b00;
    m_axi_gmem.bid = '0; m_axi_gmem.buser = '0;

    test_reset();
    test_read_burst();
    test_write();
    test_rd_backpressure();
    test_wr_gaps();
    test_busy_req();
    test_bresp_err();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
